bias_enable_sequencer: RTL and testbench

- Digital controller directly upstream of the bias current root (EN_RESL / EN_RESH inputs) that biases the 3v3 op-amp.
- Accepts requested bias modes over a valid/ready handshake and turns the two resistor-branch enables on in order (low branch, then high branch) with programmable settle waits.
- Turns them off in reverse order with discharge waits, and reports when the bias is settled.
- Sits in the digital domain of the top cell; its enables replace direct pad drive of the bias root.

---
 rtl/bias_enable_sequencer.sv | 177 +++++++++++++++++
 tb/tb_bias_enable_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bias_enable_sequencer.sv
// Bias enable sequencer: orders the two resistor-branch enables of the 3v3
// op-amp bias root. Power-up is low branch then high branch, each held for
// SETTLE_CYCLES. Power-down is the reverse order, each branch held off for
// DISCHARGE_CYCLES. Branches that are already off are skipped on power-down.
module bias_enable_sequencer #(
  parameter int SETTLE_CYCLES    = 1000,
  parameter int DISCHARGE_CYCLES = 250,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req_mode,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       en_resl,
  output logic       en_resh,
  output logic       settled,
  output logic       busy,
  output logic [1:0] cur_mode
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_UP_L = 3'd1,
    S_UP_H = 3'd2,
    S_ON   = 3'd3,
    S_DN_H = 3'd4,
    S_DN_L = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIS_LOAD = CNT_W'(DISCHARGE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       tgt_q, tgt_d;
  logic             en_resl_q, en_resl_d;
  logic             en_resh_q, en_resh_d;
  logic             settled_q, settled_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic             accept;

  // First power-up step for a target; a zero target means no power-up at all.
  function automatic state_t up_entry(input logic [1:0] t);
    if (t == 2'b00)  return S_OFF;
    else if (t[0])   return S_UP_L;
    else             return S_UP_H;
  endfunction

  // First power-down step: skip any branch that is already off.
  function automatic state_t dn_entry(input logic l, input logic h, input logic [1:0] t);
    if (h)           return S_DN_H;
    else if (l)      return S_DN_L;
    else             return up_entry(t);
  endfunction

  // Ready is withdrawn the moment ena drops so no request slips in while disabled.
  assign req_ready = ena && rdy_q;
  assign accept    = req_valid && req_ready;

  // Next-state and target selection.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_OFF: begin
        if (accept) begin
          tgt_d   = req_mode;
          state_d = up_entry(req_mode);
        end
      end
      S_UP_L: begin
        if (!ena) begin
          tgt_d   = 2'b00;
          state_d = dn_entry(en_resl_q, en_resh_q, 2'b00);
        end else if (timer_q == '0) begin
          state_d = tgt_q[1] ? S_UP_H : S_ON;
        end
      end
      S_UP_H: begin
        if (!ena) begin
          tgt_d   = 2'b00;
          state_d = dn_entry(en_resl_q, en_resh_q, 2'b00);
        end else if (timer_q == '0) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!ena) begin
          tgt_d   = 2'b00;
          state_d = dn_entry(en_resl_q, en_resh_q, 2'b00);
        end else if (accept && (req_mode != cur_mode_q)) begin
          tgt_d   = req_mode;
          state_d = dn_entry(en_resl_q, en_resh_q, req_mode);
        end
      end
      S_DN_H: begin
        if (!ena) tgt_d = 2'b00;
        if (timer_q == '0) state_d = en_resl_q ? S_DN_L : up_entry(tgt_d);
      end
      S_DN_L: begin
        if (!ena) tgt_d = 2'b00;
        if (timer_q == '0) state_d = up_entry(tgt_d);
      end
      default: state_d = S_OFF;
    endcase
  end

  // Registered outputs and step timer derived from the state being entered.
  always_comb begin
    en_resl_d  = en_resl_q;
    en_resh_d  = en_resh_q;
    timer_d    = timer_q;
    cur_mode_d = cur_mode_q;
    case (state_d)
      S_OFF:  begin en_resl_d = 1'b0; en_resh_d = 1'b0; end
      S_UP_L: en_resl_d = 1'b1;
      S_UP_H: begin en_resh_d = 1'b1; en_resl_d = tgt_d[0]; end
      S_DN_H: en_resh_d = 1'b0;
      S_DN_L: begin en_resh_d = 1'b0; en_resl_d = 1'b0; end
      default: ;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        S_UP_L, S_UP_H: timer_d = SET_LOAD;
        S_DN_H, S_DN_L: timer_d = DIS_LOAD;
        default:        timer_d = '0;
      endcase
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
    if ((state_d == S_ON) && (state_q != S_ON))
      cur_mode_d = tgt_d;
    else if (((state_q == S_DN_H) || (state_q == S_DN_L)) &&
             ((state_d == S_OFF) || (state_d == S_UP_L) || (state_d == S_UP_H)))
      cur_mode_d = 2'b00;
    settled_d = (state_d == S_ON);
    busy_d    = (state_d == S_UP_L) || (state_d == S_UP_H) ||
                (state_d == S_DN_H) || (state_d == S_DN_L);
    rdy_d     = (state_d == S_OFF) || (state_d == S_ON);
  end

  // State register; reset drops both enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      timer_q    <= '0;
      tgt_q      <= 2'b00;
      en_resl_q  <= 1'b0;
      en_resh_q  <= 1'b0;
      settled_q  <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
      cur_mode_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tgt_q      <= tgt_d;
      en_resl_q  <= en_resl_d;
      en_resh_q  <= en_resh_d;
      settled_q  <= settled_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      cur_mode_q <= cur_mode_d;
    end
  end

  assign en_resl  = en_resl_q;
  assign en_resh  = en_resh_q;
  assign settled  = settled_q;
  assign busy     = busy_q;
  assign cur_mode = cur_mode_q;

endmodule

// File: tb/tb_bias_enable_sequencer.sv
// Bench for bias_enable_sequencer: directed scenarios followed by random
// traffic, checked against a schedule-based reference model.
module tb_bias_enable_sequencer;
  localparam int SET = 4;
  localparam int DIS = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena, req_valid;
  logic [1:0] req_mode;
  logic       req_ready, en_resl, en_resh, settled, busy;
  logic [1:0] cur_mode;

  bias_enable_sequencer #(.SETTLE_CYCLES(SET), .DISCHARGE_CYCLES(DIS), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_mode(req_mode), .req_valid(req_valid),
    .req_ready(req_ready), .en_resl(en_resl), .en_resh(en_resh), .settled(settled),
    .busy(busy), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: one snapshot per cycle of expected outputs; a planned sequence is a queue.
  typedef struct packed {
    logic       l;
    logic       h;
    logic       s;
    logic       b;
    logic [1:0] cm;
    logic       up;
  } snap_t;

  snap_t      q[$];
  snap_t      cur;
  logic [1:0] T;
  logic       rdy_m;

  function automatic snap_t mk(logic l, logic h, logic s, logic b, logic [1:0] cm, logic up);
    snap_t x;
    x.l = l; x.h = h; x.s = s; x.b = b; x.cm = cm; x.up = up;
    return x;
  endfunction

  function automatic snap_t steady(logic [1:0] t);
    if (t == 2'b00) return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    return mk(t[0], t[1], 1'b1, 1'b0, t, 1'b0);
  endfunction

  task automatic plan_up(input logic [1:0] t);
    if (t[0]) for (int i = 0; i < SET; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1));
    if (t[1]) for (int i = 0; i < SET; i++) q.push_back(mk(t[0], 1'b1, 1'b0, 1'b1, 2'b00, 1'b1));
  endtask

  task automatic plan_dn(input logic l, input logic h, input logic [1:0] cm);
    if (h) for (int i = 0; i < DIS; i++) q.push_back(mk(l, 1'b0, 1'b0, 1'b1, cm, 1'b0));
    if (l) for (int i = 0; i < DIS; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, cm, 1'b0));
    plan_up(T);
  endtask

  task automatic model_reset();
    q.delete();
    cur   = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    T     = 2'b00;
    rdy_m = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [1:0] m);
    logic acc;
    acc = v && e && rdy_m;
    if (!cur.b) begin
      if (cur.s) begin
        if (!e) begin
          T = 2'b00; plan_dn(cur.l, cur.h, cur.cm);
        end else if (acc && (m != T)) begin
          T = m; plan_dn(cur.l, cur.h, cur.cm);
        end
      end else if (acc && (m != 2'b00)) begin
        T = m; plan_up(T);
      end
    end else if (!e) begin
      T = 2'b00;
      if (cur.up) begin
        q.delete();
        plan_dn(cur.l, cur.h, cur.cm);
      end else begin
        while ((q.size() > 0) && q[$].up) void'(q.pop_back());
      end
    end
    if (q.size() > 0) cur = q.pop_front();
    else              cur = steady(T);
    rdy_m = !cur.b;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("en_resl",   {1'b0, en_resl},   {1'b0, cur.l});
    chk("en_resh",   {1'b0, en_resh},   {1'b0, cur.h});
    chk("settled",   {1'b0, settled},   {1'b0, cur.s});
    chk("busy",      {1'b0, busy},      {1'b0, cur.b});
    chk("cur_mode",  cur_mode,          cur.cm);
    chk("req_ready", {1'b0, req_ready}, {1'b0, ena && rdy_m});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(ena, req_valid, req_mode);
    #1;
    check_all();
  endtask

  task automatic request(input logic [1:0] m, input int cycles);
    req_valid = 1'b1; req_mode = m;
    step();
    req_valid = 1'b0;
    repeat (cycles) step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req_valid = 1'b0; req_mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en_resl", {1'b0, en_resl}, 2'b00);
    chk("rst_en_resh", {1'b0, en_resh}, 2'b00);
    chk("rst_settled", {1'b0, settled}, 2'b00);
    chk("rst_busy",    {1'b0, busy},    2'b00);
    chk("rst_cur_mode", cur_mode,       2'b00);
    rst_n = 1'b1;
    step();

    // Power up to 11, then change to 01, then repeat 01 as a no-op.
    request(2'b11, 9);
    chk("t1_settled", {1'b0, settled}, 2'b01);
    chk("t1_mode",    cur_mode,        2'b11);
    request(2'b01, 9);
    chk("t3_mode",    cur_mode,        2'b01);
    chk("t3_resh",    {1'b0, en_resh}, 2'b00);
    req_valid = 1'b1; req_mode = 2'b01;
    repeat (3) step();
    req_valid = 1'b0;
    chk("t4_settled", {1'b0, settled},   2'b01);
    chk("t4_ready",   {1'b0, req_ready}, 2'b01);

    // Power down, then high branch only.
    request(2'b00, 6);
    request(2'b10, 6);
    chk("t2_resl",    {1'b0, en_resl}, 2'b00);
    chk("t2_resh",    {1'b0, en_resh}, 2'b01);
    chk("t2_settled", {1'b0, settled}, 2'b01);
    request(2'b00, 6);

    // Disable in the middle of UP_H with a request held.
    request(2'b11, 5);
    ena = 1'b0; req_valid = 1'b1; req_mode = 2'b11;
    repeat (8) step();
    chk("t5_resl", {1'b0, en_resl}, 2'b00);
    chk("t5_busy", {1'b0, busy},    2'b00);
    ena = 1'b1; req_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of UP_H.
    request(2'b11, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_resl",    {1'b0, en_resl}, 2'b00);
    chk("t6_resh",    {1'b0, en_resh}, 2'b00);
    chk("t6_settled", {1'b0, settled}, 2'b00);
    chk("t6_busy",    {1'b0, busy},    2'b00);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("t6_ready", {1'b0, req_ready}, 2'b01);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      ena       = ($urandom_range(0, 19) != 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_mode  = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
